// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an up/down counter: paces enable pulses with a prescaler
// and stops or turns around when the fed-back count reaches the latched target.
module counter_seq_ctrl #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] count,
    output logic             enable,
    output logic             direction,
    output logic             busy,
    output logic             done
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] M_UP_ONCE   = 2'b00;
    localparam logic [1:0] M_DOWN_ONCE = 2'b01;
    localparam logic [1:0] M_PING_PONG = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             enable_q, enable_d;
    logic             direction_q, direction_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic tick;
    logic hit_target;
    logic at_zero;

    assign tick       = (presc_q == PRESC_LAST) && !hold;
    assign hit_target = (count == target_q);
    assign at_zero    = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            mode_q      <= '0;
            target_q    <= '0;
            enable_q    <= 1'b0;
            direction_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            mode_q      <= mode_d;
            target_q    <= target_d;
            enable_q    <= enable_d;
            direction_q <= direction_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        mode_d      = mode_q;
        target_d    = target_q;
        enable_d    = 1'b0;
        direction_d = direction_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    mode_d   = mode;
                    target_d = target;
                    presc_d  = '0;
                    busy_d   = 1'b1;
                    if (mode == M_DOWN_ONCE) begin
                        state_d     = S_DOWN;
                        direction_d = 1'b0;
                    end else begin
                        state_d     = S_UP;
                        direction_d = 1'b1;
                    end
                end
            end

            S_UP, S_DOWN: begin
                if (stop) begin
                    // Abort beats any tick landing in the same cycle.
                    state_d     = S_IDLE;
                    presc_d     = '0;
                    direction_d = 1'b1;
                    busy_d      = 1'b0;
                end else if (!hold) begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        enable_d = 1'b1;
                        if (state_q == S_UP) begin
                            if (mode_q == M_UP_ONCE && hit_target) begin
                                enable_d    = 1'b0;
                                done_d      = 1'b1;
                                state_d     = S_IDLE;
                                presc_d     = '0;
                                direction_d = 1'b1;
                                busy_d      = 1'b0;
                            end else if (mode_q == M_PING_PONG && hit_target) begin
                                // Turnaround pulse already counts down.
                                state_d     = S_DOWN;
                                direction_d = 1'b0;
                            end
                        end else begin
                            if ((mode_q == M_PING_PONG) ? at_zero : hit_target) begin
                                enable_d    = 1'b0;
                                done_d      = 1'b1;
                                state_d     = S_IDLE;
                                presc_d     = '0;
                                direction_d = 1'b1;
                                busy_d      = 1'b0;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                presc_d     = '0;
                direction_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign enable    = enable_q;
    assign direction = direction_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller for the up/down counter. It turns start/stop commands and a run mode into a paced `enable` pulse train and a `direction` level for the counter, and watches the counter's `count` output to stop or turn around at a programmed target. It sits between the user controls (buttons/switches) and the counter. A built-in prescaler makes a visible count rate on the board clock.

## Interface
- `WIDTH`, default 6: width of `count` and `target`; matches the counter.
- `PRESCALE`, default 25_000_000: clocks between enable pulses. Must be at least 2.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle command to begin a run. Ignored while `busy`.
- `stop` in 1: one-cycle abort command. Accepted in any state.
- `hold` in 1: level input. While high, the prescaler freezes and no enable pulses are issued. The current state is kept.
- `mode` in 2: run mode, sampled when `start` is accepted.
  - 00 up-once
  - 01 down-once
  - 10 ping-pong (up to target, then down to 0)
  - 11 continuous up
- `target` in WIDTH: stop or turnaround value, sampled when `start` is accepted.
- `count` in WIDTH: feedback from the counter's `count`.
- `enable` out 1: one-cycle pulse to the counter's `enable`.
- `direction` out 1: to the counter's `direction`. 1 = up, 0 = down.
- `busy` out 1: high in the UP and DOWN states.
- `done` out 1: one-cycle pulse when a run completes normally.

## Operation
- States:
  - IDLE
  - UP
  - DOWN
- All outputs are registered.
- Reset values:
  - state IDLE
  - prescaler 0
  - `enable` 0
  - `direction` 1
  - `busy` 0
  - `done` 0
  - latched mode and target 0
- IDLE, when `start` is high and `stop` is low:
  - latch `mode` and `target`
  - clear the prescaler
  - go to DOWN if mode=01, otherwise UP
  - set `direction` to 0 for DOWN, 1 for UP
- Prescaler: counts 0..PRESCALE-1 while in UP or DOWN with `hold` low. A tick is the cycle it equals PRESCALE-1; it wraps to 0 after the tick.
- On a tick, `count` is compared before any pulse is issued:
  - UP, mode 00: if count==target, `done` is pulsed and the block goes to IDLE. Otherwise `enable` is pulsed.
  - UP, mode 10: if count==target, go to DOWN, drive `direction`=0 and pulse `enable` together. Otherwise pulse `enable` with `direction`=1.
  - UP, mode 11: always pulse `enable`. `target` is ignored and the counter wraps on its own. Only `stop` ends the run.
  - DOWN, mode 01: if count==target, pulse `done` and go to IDLE. Otherwise pulse `enable`.
  - DOWN, mode 10: if count==0, pulse `done` and go to IDLE. Otherwise pulse `enable`.
- Entering IDLE (done, stop or reset): `direction` returns to 1, `busy` goes to 0, and `enable` is 0.
- Boundary rules:
  - Start with count already equal to target (modes 00/01): no enable pulse at all. `done` fires at the first tick.
  - Ping-pong with target=0: the turnaround happens at the first tick, then the block waits for the counter to return to 0.
  - `stop` and `start` in the same cycle: `stop` wins and the block stays in IDLE.
  - `stop` in the same cycle as a tick: no enable pulse and no done.
  - `hold` during a tick cycle: the tick is suppressed and the prescaler value is kept.
  - Reset in mid-run: the block returns to its reset values at the next edge with no pulses. The counter itself is reset separately.

## Timing
- Cycle numbering: `start` is high in cycle 0.
  - `busy` is high from cycle 1 and the prescaler is 0 in cycle 1.
  - The first tick is in cycle PRESCALE.
  - The first `enable` is high in cycle PRESCALE+1.
  - The counter updates at the end of that cycle, so the new count is visible from cycle PRESCALE+2.
- Ticks occur at cycles k·PRESCALE (k ≥ 1) while `hold` is low. Each held cycle delays all later ticks by one.
- `done` and the IDLE state (with `busy` low) appear in the cycle after the deciding tick.
- `stop` accepted in cycle n: `busy` is 0 and `enable` is 0 in cycle n+1.
- PRESCALE ≥ 2 guarantees that every compare sees the count after the previous pulse.

## Test plan
All scenarios use PRESCALE=4 and WIDTH=6, with a behavioural counter model (increment/decrement on `enable`, reset to 0).
- Up-once, count=0, target=5: ticks at cycles 4..24, `enable` high in cycles 5, 9, 13, 17, 21 with `direction`=1, count=5 from cycle 22, `done` in cycle 25, `busy` low from cycle 25.
- Down-once, count=5, target=2: 3 enable pulses with `direction`=0, `done` once at count=2, `direction` back to 1 in IDLE.
- Ping-pong, target=3 from count=0: 3 pulses up, then a turnaround pulse with `direction`=0 and 2 more down pulses (3 down in total), count ends at 0, exactly one `done`.
- Boundaries:
  - start with count==target (mode 00) gives no enable and `done` in cycle 5
  - start+stop in the same cycle leaves `busy` at 0
  - `start` while busy is ignored
- Hold high for 6 cycles during up-once: every later `enable` shifts by 6 cycles and the final count is unchanged.
- Continuous up: 70 pulses wrap the counter past 63, no `done`. Then `stop` makes `busy` 0 and `enable` 0 in the next cycle. Reset in mid-run restores all reset values in the next cycle.
